// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the RV64 memory-access stage.
//   - funct3 size/sign encodings (F3_B .. F3_WU)
//   - FSM state enum
//   - byte-lane size masks plus helpers for the mask, natural-alignment
//     clear bits and misalignment detection
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // funct3[1:0] selects size; 111 decodes as D.
  function automatic logic [7:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = MASK_B;
      2'b01:   size_mask = MASK_H;
      2'b10:   size_mask = MASK_W;
      default: size_mask = MASK_D;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_bits(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   align_bits = 3'b000;
      2'b01:   align_bits = 3'b001;
      2'b10:   align_bits = 3'b011;
      default: align_bits = 3'b111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    is_misaligned = |(off & align_bits(f3));
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: registered request/ready bus to the 64-bit data memory.
//   master: the M stage (drives dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb)
//   slave : the data memory (drives dm_ready/dm_rdata)
// dm_rdata is meaningful only in a cycle with dm_ready & !dm_we.
interface mem_access_stage_if #(
  parameter int N      = 64,
  parameter int STRB_W = N/8
);
  logic              dm_req;
  logic              dm_we;
  logic [N-1:0]      dm_addr;
  logic [N-1:0]      dm_wdata;
  logic [STRB_W-1:0] dm_wstrb;
  logic              dm_ready;
  logic [N-1:0]      dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the M stage.
//   funct3   in  size/sign of the access
//   offset   in  byte offset within the doubleword (already aligned if needed)
//   st_data  in  right-aligned store data
//   ld_raw   in  raw doubleword from memory
//   wdata    out store data shifted onto its byte lanes
//   wstrb    out byte strobes for the access
//   ld_ext   out load value extracted from its lanes and sign/zero extended
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int N      = 64,
  parameter int STRB_W = N/8
) (
  input  logic [2:0]        funct3,
  input  logic [2:0]        offset,
  input  logic [N-1:0]      st_data,
  input  logic [N-1:0]      ld_raw,
  output logic [N-1:0]      wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [N-1:0]      ld_ext
);

  logic [5:0]   bit_sh;
  logic [N-1:0] ld_sh;
  logic         sgn;

  assign bit_sh = {offset, 3'b000};
  assign wdata  = st_data << bit_sh;
  assign wstrb  = size_mask(funct3) << offset;
  assign ld_sh  = ld_raw >> bit_sh;
  // BU/HU/WU have funct3[2] set; 111 falls into the D branch and is unaffected.
  assign sgn    = ~funct3[2];

  always_comb begin
    ld_ext = ld_sh;
    case (funct3[1:0])
      2'b00:   ld_ext = {{(N-8){sgn & ld_sh[7]}},   ld_sh[7:0]};
      2'b01:   ld_ext = {{(N-16){sgn & ld_sh[15]}}, ld_sh[15:0]};
      2'b10:   ld_ext = {{(N-32){sgn & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64 M stage. Turns the EX/MEM address and store data
// into one registered request on the data-memory bus, waits for dm_ready,
// extracts/extends load data, and stalls upstream until the access is done.
//   clk, reset_n           clock, async active-low reset
//   valid_M, flush_M       instruction valid / kill
//   memRead_M, memWrite_M  load / store
//   funct3_M               size/sign (B,H,W,D,BU,HU,WU; 111 = D)
//   aluResult_M            effective byte address
//   writeData_M            right-aligned store data
//   dm                     memory bus (master side)
//   readData_M             extended load result (held between loads)
//   stall_M                hold upstream stages
//   misaligned_M           access misaligned for its size
// Optional: define MEM_MISALIGN_CHECK_EN to flag misaligned accesses and
// suppress them; otherwise low address bits are forced to natural alignment
// and the access always proceeds.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int N      = 64,
  parameter int STRB_W = N/8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       valid_M,
  input  logic                       flush_M,
  input  logic                       memRead_M,
  input  logic                       memWrite_M,
  input  logic [2:0]                 funct3_M,
  input  logic [N-1:0]               aluResult_M,
  input  logic [N-1:0]               writeData_M,
  mem_access_stage_if.master         dm,
  output logic [N-1:0]               readData_M,
  output logic                       stall_M,
  output logic                       misaligned_M
);

  mem_state_e        state;
  logic              acc, mis;
  logic [2:0]        off_cur;
  // Access attributes captured at issue; upstream may move on after a flush.
  logic [2:0]        lat_f3, lat_off;
  logic              lat_load;
  logic              killed;
  logic [2:0]        f3_sel, off_sel;
  logic [N-1:0]      al_wdata, al_ld;
  logic [STRB_W-1:0] al_wstrb;

  assign acc = valid_M & (memRead_M | memWrite_M) & ~flush_M;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis          = is_misaligned(funct3_M, aluResult_M[2:0]);
  assign off_cur      = aluResult_M[2:0];
  assign misaligned_M = reset_n & acc & mis;
`else
  assign mis          = 1'b0;
  assign off_cur      = aluResult_M[2:0] & ~align_bits(funct3_M);
  assign misaligned_M = 1'b0;
`endif

  // Gated by reset_n so the output sits at its reset value while in reset.
  assign stall_M = reset_n & acc & ~mis & (state != DONE);

  // One aligner shared: store steering is needed only at issue (IDLE),
  // load extraction only while the access is outstanding.
  assign f3_sel  = (state == IDLE) ? funct3_M : lat_f3;
  assign off_sel = (state == IDLE) ? off_cur  : lat_off;

  mem_lane_align #(.N(N), .STRB_W(STRB_W)) u_align (
    .funct3  (f3_sel),
    .offset  (off_sel),
    .st_data (writeData_M),
    .ld_raw  (dm.dm_rdata),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .ld_ext  (al_ld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wdata <= '0;
      dm.dm_wstrb <= '0;
      readData_M  <= '0;
      lat_f3      <= '0;
      lat_off     <= '0;
      lat_load    <= 1'b0;
      killed      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !mis) begin
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= memWrite_M;
            dm.dm_addr  <= {aluResult_M[N-1:3], 3'b000};
            dm.dm_wdata <= al_wdata;
            dm.dm_wstrb <= al_wstrb;
            lat_f3      <= funct3_M;
            lat_off     <= off_cur;
            lat_load    <= ~memWrite_M;
            killed      <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // A flush cannot cancel the bus transaction; it only drops the result.
          killed <= killed | flush_M;
          if (dm.dm_ready) begin
            dm.dm_req <= 1'b0;
            if (lat_load && !killed && !flush_M)
              readData_M <= al_ld;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
